vx_dvstack_ctl: RTL

VX_DVSTACK_CTL -- requirements
Module: VX_dvstack_ctl

---
 rtl/vx_dvstack_ctl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vx_dvstack_ctl.sv
// vx_dvstack_ctl: per-warp divergence stack controller for split/join.
// Divergent splits push {reconvergence mask, else path}; joins pop one entry per request.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef DV_STACK_SIZE
`define DV_STACK_SIZE 4
`endif
`ifndef PC_BITS
`define PC_BITS 32
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef NW_WIDTH
`define NW_WIDTH `CLOG2(`NUM_WARPS)
`endif

module vx_dvstack_ctl #(
    parameter int NUM_WARPS = `NUM_WARPS,
    parameter int NUM_THREADS = `NUM_THREADS,
    parameter int DEPTH = `DV_STACK_SIZE,
    localparam int PTRW = `CLOG2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [`NW_WIDTH-1:0]   req_wid,
    input  logic                   req_is_split,
    input  logic                   req_is_join,
    input  logic                   req_is_dvg,
    input  logic [NUM_THREADS-1:0] req_then_tmask,
    input  logic [NUM_THREADS-1:0] req_else_tmask,
    input  logic [NUM_THREADS-1:0] req_cur_tmask,
    input  logic [`PC_BITS-1:0]    req_next_pc,
    input  logic [PTRW-1:0]        req_stack_ptr,
    input  logic [`NW_WIDTH-1:0]   dvstack_wid,
    output logic [PTRW-1:0]        dvstack_ptr,
    output logic                   upd_valid,
    output logic [`NW_WIDTH-1:0]   upd_wid,
    output logic [NUM_THREADS-1:0] upd_tmask,
    output logic                   upd_pc_valid,
    output logic [`PC_BITS-1:0]    upd_pc,
    output logic                   err_ovf,
    output logic                   err_unf
);
    localparam int SW = `CLOG2(DEPTH);
    localparam logic [PTRW-1:0] PMAX = PTRW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, PUSH2, POP} state_t;

    state_t                 state;
    logic [PTRW-1:0]        ptr [NUM_WARPS];
    logic [NUM_THREADS-1:0] mem_tmask [NUM_WARPS][DEPTH];
    logic [`PC_BITS-1:0]    mem_pc [NUM_WARPS][DEPTH];
    logic                   mem_ft [NUM_WARPS][DEPTH];
    logic [`NW_WIDTH-1:0]   wid_r;
    logic [NUM_THREADS-1:0] then_r, else_r, rd_tmask;
    logic [`PC_BITS-1:0]    pc_r, rd_pc;
    logic                   rd_ft;
    logic [PTRW-1:0]        cur_ptr, top_ptr;
    logic                   fire, do_split, do_join, push_ok;
    logic                   we, wd_ft;
    logic [`NW_WIDTH-1:0]   wa_w;
    logic [SW-1:0]          wa_s;
    logic [NUM_THREADS-1:0] wd_tmask;
    logic [`PC_BITS-1:0]    wd_pc;

    assign req_ready   = state == IDLE;
    assign fire        = req_valid && req_ready;
    assign do_split    = fire && req_is_split && !req_is_join;
    assign do_join     = fire && req_is_join && !req_is_split;
    assign cur_ptr     = ptr[req_wid];
    assign top_ptr     = ptr[wid_r];
    assign dvstack_ptr = ptr[dvstack_wid];
    assign push_ok     = req_is_dvg && cur_ptr <= PMAX;

    // Single write port: the accept cycle writes the reconvergence entry, PUSH2 the else entry.
    always_comb begin
        we       = (do_split && push_ok) || state == PUSH2;
        wa_w     = state == PUSH2 ? wid_r : req_wid;
        wa_s     = state == PUSH2 ? SW'(top_ptr + PTRW'(1)) : SW'(cur_ptr);
        wd_tmask = state == PUSH2 ? else_r : req_cur_tmask;
        wd_pc    = state == PUSH2 ? pc_r : req_next_pc;
        wd_ft    = state != PUSH2;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_tmask[wa_w][wa_s] <= wd_tmask;
            mem_pc[wa_w][wa_s]    <= wd_pc;
            mem_ft[wa_w][wa_s]    <= wd_ft;
        end
        if (do_join) begin
            rd_tmask <= mem_tmask[req_wid][SW'(cur_ptr - PTRW'(1))];
            rd_pc    <= mem_pc[req_wid][SW'(cur_ptr - PTRW'(1))];
            rd_ft    <= mem_ft[req_wid][SW'(cur_ptr - PTRW'(1))];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            for (int i = 0; i < NUM_WARPS; i++) ptr[i] <= '0;
            upd_valid    <= 1'b0;
            upd_pc_valid <= 1'b0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_split) begin
                        wid_r  <= req_wid;
                        then_r <= req_then_tmask;
                        else_r <= req_else_tmask;
                        pc_r   <= req_next_pc;
                        if (push_ok) begin
                            state <= PUSH2;
                        end else begin
                            // Non-divergent or full stack: continue on the taken path.
                            upd_valid    <= 1'b1;
                            upd_wid      <= req_wid;
                            upd_tmask    <= req_then_tmask;
                            upd_pc_valid <= 1'b0;
                            err_ovf      <= req_is_dvg;
                        end
                    end else if (do_join && req_stack_ptr != cur_ptr) begin
                        if (cur_ptr != '0) begin
                            wid_r <= req_wid;
                            state <= POP;
                        end else begin
                            err_unf <= 1'b1;
                        end
                    end
                end
                PUSH2: begin
                    ptr[wid_r]   <= top_ptr + PTRW'(2);
                    upd_valid    <= 1'b1;
                    upd_wid      <= wid_r;
                    upd_tmask    <= then_r;
                    upd_pc_valid <= 1'b0;
                    state        <= IDLE;
                end
                POP: begin
                    ptr[wid_r]   <= top_ptr - PTRW'(1);
                    upd_valid    <= 1'b1;
                    upd_wid      <= wid_r;
                    upd_tmask    <= rd_tmask;
                    upd_pc_valid <= !rd_ft;
                    upd_pc       <= rd_pc;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
